// File: rtl/mul_slice_sequencer.sv
// Sequences a WIDTH x WIDTH multiply through one WIDTH x SLICE slice multiplier,
// accumulating each shifted partial product into a 2*WIDTH-bit result.
module mul_slice_sequencer #(
  parameter int WIDTH = 1024,
  parameter int SLICE = 256,
  localparam int NSLICE = WIDTH / SLICE,
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [SLICE-1:0]         mul_b,
  input  logic                     mul_done,
  input  logic [WIDTH+SLICE-1:0]   mul_p,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_p,
  output logic                     busy,
  output logic [KW-1:0]            slice_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  state_t                   state;
  state_t                   state_nxt;
  logic [WIDTH-1:0]         a_reg;
  logic [WIDTH-1:0]         b_reg;
  logic [WIDTH+SLICE-1:0]   p_reg;
  logic [2*WIDTH-1:0]       acc;
  logic [KW-1:0]            k;

  // Zero-extend a slice product and shift it to the weight of slice idx.
  function automatic logic [2*WIDTH-1:0] place(input logic [WIDTH+SLICE-1:0] p,
                                               input logic [KW-1:0] idx);
    logic [2*WIDTH-1:0] ext;
    ext = (2*WIDTH)'(p);
    return ext << (32'(idx) * SLICE);
  endfunction

  // rstn is an active-high synchronous reset.
  always_ff @(posedge clk) begin
    if (rstn) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    slice_idx = '0;
    mul_a     = a_reg;
    mul_b     = '0;
    out_p     = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        slice_idx = k;
        mul_b     = SLICE'(b_reg >> (32'(k) * SLICE));
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        slice_idx = k;
        mul_b     = SLICE'(b_reg >> (32'(k) * SLICE));
        if (mul_done) state_nxt = S_ACC;
      end
      S_ACC: begin
        slice_idx = k;
        state_nxt = (k == KLAST) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_p     = acc;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, partial-product register and accumulator.
  always_ff @(posedge clk) begin
    if (rstn) begin
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
      acc   <= '0;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            acc   <= '0;
            k     <= '0;
          end
        end
        S_WAIT: begin
          if (mul_done) p_reg <= mul_p;
        end
        S_ACC: begin
          acc <= acc + place(p_reg, k);
          if (k != KLAST) k <= k + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_slice_sequencer.sv
// Scoreboard bench for mul_slice_sequencer with a behavioural slice multiplier
// of programmable latency and injectable stray mul_done pulses.
module tb_mul_slice_sequencer;
  localparam int WIDTH  = 1024;
  localparam int SLICE  = 256;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int PW     = WIDTH + SLICE;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a = '0;
  logic [WIDTH-1:0]   in_b = '0;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [SLICE-1:0]   mul_b;
  logic               mul_done;
  logic [PW-1:0]      mul_p;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [2*WIDTH-1:0] out_p;
  logic               busy;
  logic [1:0]         slice_idx;

  mul_slice_sequencer #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .busy(busy), .slice_idx(slice_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_w(input string name, input logic [2*WIDTH-1:0] act,
                       input logic [2*WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got hi64=%h lo64=%h, expected hi64=%h lo64=%h", name,
               act[2*WIDTH-1 -: 64], act[63:0], exp[2*WIDTH-1 -: 64], exp[63:0]);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [2*WIDTH-1:0] rnd_w();
    logic [2*WIDTH-1:0] r;
    for (int i = 0; i < 2*WIDTH/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Slice multiplier model plus stray-pulse injector (single process for determinism)
  int           lat = 1;
  int           cnt = 0;
  int           spur_n = 0;
  bit           spur_issue = 0;
  bit           late_fire = 0;
  bit           in_acc = 0;
  logic         model_done = 1'b0;
  logic         spur_done = 1'b0;
  logic [PW-1:0] model_p = '0;
  logic [PW-1:0] spur_p = '0;
  logic [WIDTH-1:0] ma = '0;
  logic [SLICE-1:0] mb = '0;

  assign mul_done = model_done | spur_done;
  assign mul_p    = model_done ? model_p : spur_p;

  always @(negedge clk) begin
    in_acc     = model_done && busy;
    model_done = 1'b0;
    spur_done  = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        model_done = 1'b1;
        model_p    = PW'(ma) * PW'(mb);
        if (busy) chk_w("mul_a_hold", 2048'(mul_a), 2048'(ma));
        else      late_fire = 1;
      end
    end
    if (spur_n > 0) begin
      spur_done = 1'b1;
      spur_n--;
    end else if (spur_issue && (mul_start || in_acc)) begin
      spur_done = 1'b1;
    end
    if (spur_done) spur_p = PW'(rnd_w());
    if (mul_start) begin
      ma  = mul_a;
      mb  = mul_b;
      cnt = lat;
    end
  end

  // Scoreboard and output monitor
  logic [2*WIDTH-1:0] exp_q[$];
  logic [2*WIDTH-1:0] e_mon;
  logic [2*WIDTH-1:0] last_out = '0;
  int               n_out = 0;
  int               vrise = -1;
  bit               prev_ov = 0;
  int               st_cyc[$];
  int               st_idx[$];
  logic [SLICE-1:0] st_b[$];

  always @(negedge clk) begin
    if (mul_start) begin
      st_cyc.push_back(cyc);
      st_idx.push_back(int'(slice_idx));
      st_b.push_back(mul_b);
    end
    if (out_valid && !prev_ov) vrise = cyc;
    prev_ov = out_valid;
    if (!out_valid) chk_w("out_p_zero_when_idle", out_p, '0);
    if (out_valid && out_ready) begin
      n_out++;
      last_out = out_p;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: product lo64=%h with empty scoreboard", out_p[63:0]);
      end else begin
        e_mon = exp_q.pop_front();
        chk_w("product", out_p, e_mon);
      end
    end
  end

  int t0 = 0;

  task automatic clear_log();
    st_cyc.delete();
    st_idx.delete();
    st_b.delete();
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit hold);
    bit ok = 0;
    @(posedge clk); #1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      fail("accept");
      in_valid = 1'b0;
      return;
    end
    t0 = cyc;
    exp_q.push_back(2048'(a) * 2048'(b));
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) return;
    end
    fail("wait_idle");
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    fail("wait_valid");
  endtask

  task automatic check_starts(input logic [WIDTH-1:0] b, input int l, input string tag);
    chk_i({tag, "_n_start"}, st_cyc.size(), NSLICE);
    for (int i = 0; i < NSLICE && i < st_cyc.size(); i++) begin
      chk_i({tag, "_start_cyc"}, st_cyc[i] - t0, 1 + i*(l+2));
      chk_i({tag, "_slice_idx"}, st_idx[i], i);
      chk_w({tag, "_mul_b"}, 2048'(st_b[i]), 2048'(b[i*SLICE +: SLICE]));
    end
    chk_i({tag, "_valid_rise"}, vrise - t0, 1 + NSLICE*(l+2));
  endtask

  logic [WIDTH-1:0]   a_v, b_v;
  logic [2*WIDTH-1:0] ref_v;
  int                 n0;
  bit                 found;

  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b0;

    // Idle after reset, with a stray mul_done
    spur_n = 1;
    repeat (5) @(negedge clk);
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_b("rst_mul_start", mul_start, 1'b0);
    chk_w("rst_out_p", out_p, '0);
    chk_w("rst_mul_a", 2048'(mul_a), '0);
    chk_i("rst_slice_idx", int'(slice_idx), 0);

    // 3 * 5 with single-cycle multiplier
    lat = 1;
    clear_log();
    send(WIDTH'(3), WIDTH'(5), 0);
    wait_idle();
    check_starts(WIDTH'(5), 1, "small");
    chk_w("prod_3x5", last_out, 2048'(15));

    // All-ones operands, latency 3
    lat = 3;
    clear_log();
    a_v = '1;
    send(a_v, a_v, 0);
    wait_idle();
    check_starts(a_v, 3, "ones");
    chk_w("prod_ones", last_out, 2048'(0) - (2048'(1) << 1025) + 2048'(1));

    // Only slice 3 nonzero; in_valid held high while busy
    lat = 2;
    clear_log();
    n0 = n_out;
    b_v = '0;
    b_v[768] = 1'b1;
    send(WIDTH'(32'hDEADBEEF), b_v, 1);
    wait_valid();
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk_i("hold_one_txn", n_out - n0, 1);
    chk_w("prod_slice3", last_out, 2048'(32'hDEADBEEF) << 768);
    chk_i("hold_n_start", st_cyc.size(), NSLICE);
    chk_b("hold_idle", busy, 1'b0);

    // Output back-pressure
    lat = 1;
    @(posedge clk); #1 out_ready = 1'b0;
    a_v = WIDTH'(rnd_w());
    b_v = WIDTH'(rnd_w());
    ref_v = 2048'(a_v) * 2048'(b_v);
    send(a_v, b_v, 0);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_b("stall_valid", out_valid, 1'b1);
      chk_b("stall_in_ready", in_ready, 1'b0);
      chk_w("stall_out_p", out_p, ref_v);
      if (i == 3) spur_n = 1;
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk_b("accept_valid", out_valid, 1'b1);
    @(negedge clk);
    chk_b("after_accept_valid", out_valid, 1'b0);
    chk_b("after_accept_in_ready", in_ready, 1'b1);

    // Reset during WAIT of slice 2, then a late mul_done
    lat = 8;
    late_fire = 0;
    send(WIDTH'(rnd_w()), WIDTH'(rnd_w()), 0);
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (mul_start && slice_idx == 2'd2) begin
        found = 1;
        break;
      end
    end
    if (!found) fail("reach_slice2");
    repeat (3) @(negedge clk);
    chk_b("wait_busy", busy, 1'b1);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1 rstn = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    n0 = n_out;
    @(negedge clk);
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_in_ready", in_ready, 1'b1);
    chk_b("abort_mul_start", mul_start, 1'b0);
    chk_i("abort_slice_idx", int'(slice_idx), 0);
    repeat (20) @(negedge clk);
    chk_b("late_done_seen", late_fire, 1'b1);
    chk_i("abort_no_output", n_out - n0, 0);
    chk_b("abort_still_idle", busy, 1'b0);
    lat = 1;
    send(WIDTH'(7), WIDTH'(6), 0);
    wait_idle();
    chk_w("prod_7x6", last_out, 2048'(42));

    // Randomized operands, latencies and stray pulses in ISSUE/ACC
    for (int it = 0; it < 8; it++) begin
      lat = $urandom_range(1, 4);
      spur_issue = $urandom_range(0, 1);
      a_v = WIDTH'(rnd_w());
      b_v = WIDTH'(rnd_w());
      if (it == 2) a_v = '0;
      if (it == 5) b_v = '1;
      clear_log();
      send(a_v, b_v, 0);
      wait_idle();
      check_starts(b_v, lat, "rand");
    end
    spur_issue = 0;

    repeat (5) @(negedge clk);
    chk_i("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation bound expired");
    $fatal(1);
  end

endmodule

// File: doc/mul_slice_sequencer.md
Name: mul_slice_sequencer

Overview:
- Time-multiplexed controller for 1024x1024 multiplication using a single 1024x256 serial multiplier slice instead of four parallel copies.
- Accepts an operand pair over a valid/ready handshake and issues the four 256-bit slices of In2 to the shared slice multiplier in turn.
- Accumulates each partial product, shifted into place, into a 2048-bit register.
- Presents the final product over a valid/ready output handshake. Sits between the operand source and the slice multiplier in the large-multiplication datapath.

Parameters:
- WIDTH, 1024, operand width in bits.
- SLICE, 256, In2 slice width per multiplier pass. WIDTH must be an integer multiple of SLICE.
- NSLICE, WIDTH/SLICE (4), derived local parameter, not overridable.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rstn  in  1  synchronous, active-high reset (1 = reset), sampled on the clk rising edge.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  WIDTH  multiplicand (In1).
- in_b  in  WIDTH  multiplier (In2).
- mul_start  out  1  one-cycle pulse launching one slice multiplication.
- mul_a  out  WIDTH  latched multiplicand to the slice multiplier.
- mul_b  out  SLICE  current In2 slice to the slice multiplier.
- mul_done  in  1  slice multiplier result valid; single-cycle pulse.
- mul_p  in  WIDTH+SLICE  slice product.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- out_p  out  2*WIDTH  full product.
- busy  out  1  high in every state except IDLE.
- slice_idx  out  clog2(NSLICE)  index of the slice being processed.

Behaviour:
- Reset values: state IDLE, all outputs 0 except in_ready=1. Operand, accumulator and slice_idx registers are cleared.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a into the A register and in_b into the B register, clear the accumulator, set k=0, go to ISSUE.
- State ISSUE:
  - mul_start=1 for exactly this cycle.
  - mul_b=B[k*SLICE +: SLICE]. mul_a=A, held stable from ISSUE through WAIT.
  - Go to WAIT.
- State WAIT:
  - Hold until mul_done=1.
  - On mul_done, register mul_p into P and go to ACC.
  - mul_done arriving in the ISSUE cycle is not sampled. The slice multiplier latency L (start to done) is at least 1 cycle.
- State ACC:
  - acc <= acc + (P << (k*SLICE)), computed in 2*WIDTH bits. The sum cannot overflow because the exact product fits in 2*WIDTH bits.
  - If k==NSLICE-1, go to DONE. Otherwise k<=k+1 and go to ISSUE.
- State DONE:
  - out_valid=1 and out_p=acc, both held stable until out_ready=1.
  - On out_valid&&out_ready, go to IDLE in the next cycle.
  - in_ready stays 0 in DONE; there is no same-cycle turnaround.
- Latency: accept at cycle T0. First ISSUE at T0+1. out_valid rises at T0+1+NSLICE*(L+2). With L=1 this is T0+13.
- out_p is 0 whenever out_valid=0.
- slice_idx=k in ISSUE, WAIT and ACC; 0 otherwise.
- mul_done outside WAIT is ignored, with no state or accumulator change.
- in_valid while busy is ignored; the operands are not latched.
- Reset asserted in any state, including mid-WAIT: next state IDLE, all registers cleared, mul_start deasserted. A late mul_done from the aborted pass is ignored because the block is then in IDLE.
- No timeout: WAIT holds indefinitely if mul_done never arrives.

Test Plan:
- Reset, then idle for 5 cycles -> in_ready=1; busy, out_valid, mul_start=0; out_p=0; spurious mul_done pulses cause no change.
- A=3, B=5, model multiplier with L=1 -> mul_start pulses at T0+1, +4, +7, +10 with mul_b=5,0,0,0. out_valid at T0+13 with out_p=15.
- A=B=2^1024-1, L=3 -> out_p=2^2048-2^1025+1. Exactly 4 mul_start pulses with slice_idx 0..3.
- B=2^768 (only slice 3 nonzero), A=0xDEADBEEF -> out_p=0xDEADBEEF<<768. in_valid held high during busy is ignored, so only one transaction completes.
- out_ready=0 for 10 cycles after out_valid -> out_p stable and in_ready=0 throughout. Raising out_ready gives one-cycle acceptance, then IDLE with in_ready=1.
- rstn pulsed during WAIT of slice 2, then a late mul_done -> IDLE, no out_valid. A following A=7, B=6 transaction yields out_p=42.
